lhn_seq_mult_ctrl: RTL and testbench
====================================

// Module: lhn_seq_mult_ctrl
// PURPOSE
//   Sequencer for the shift-add multiplier iteration (partial-high/multiplier-shift step).
//   Accepts one operand pair per start request and iterates the add/shift step NW times.
//   Returns the unsigned product with a busy/done handshake.
//   Sits between the ALU operand bus and the result mux; this is the sequential
//   (non-pipelined) multiply path.
// PARAMETERS
//   MW   7   multiplicand (M) and partial-high (ph) width
//   NW   4   multiplier (mpl) width; equals the number of iterations
//   CW   2   iteration counter width, ceil(log2(NW)); must hold NW-1
// PORTS
//   clock     in   1      single clock, all state updates on rising edge
//   Rst       in   1      synchronous reset, active-high; priority over every other input
//   start     in   1      request; sampled only in IDLE or DONE
//   M_in      in   MW     multiplicand, sampled on the edge that accepts start
//   mpl_in    in   NW     multiplier, sampled on the edge that accepts start
//   busy      out  1      high while an operation is accepted and not yet complete (RUN)
//   done      out  1      one-cycle pulse, product valid
//   product   out  MW+NW  unsigned M_in*mpl_in; holds until the next completion
//   iter      out  CW     current iteration index (debug); 0 outside RUN
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, product=0, iter=0; internal M/ph/mpl regs=0.
//   Reset mid-operation aborts the operation: no done pulse, product returns to 0.
//   States: IDLE, RUN, DONE (2-bit encoding; unused code -> IDLE on next edge).
//   IDLE: start=1 at edge E0 -> load M=M_in, ph=0, mpl=mpl_in, iter=0; go RUN.
//     start=0 -> stay IDLE.
//   RUN: each edge performs one step, then iter<=iter+1:
//     pp = mpl[0] ? M : 0;  {c,s} = ph + pp (MW+1 bits, no truncation before shift)
//     ph <= {c, s[MW-1:1]};  mpl <= {s[0], mpl[NW-1:1]};  M unchanged.
//   On the step with iter==NW-1 (edge E_NW): product <= {ph_next, mpl_next}, iter<=0; go DONE.
//   DONE: done=1, busy=0 for exactly one cycle.
//     Next edge: start=1 -> accept new operands as from IDLE (back-to-back, no bubble).
//     Otherwise -> IDLE.
//   start while RUN is ignored: operands not sampled, no queuing, no error.
//   Latency: start accepted at E0; done high in the cycle following E_NW,
//     i.e. NW+1 rising edges after the request cycle.
//     Throughput: one result per NW+1 cycles.
//   busy is a registered decode of state==RUN; done is a registered decode of state==DONE.
//   Operands (M_in, mpl_in) may change freely after E0 without affecting the result.
//   No overflow possible: (2^MW-1)*(2^NW-1) < 2^(MW+NW).
//   product updates only on entry to DONE; it is never partially visible during RUN.
// TESTING
//   1 Reset: Rst=1 for 2 cycles with start=1 -> busy=0, done=0, product=0, iter=0.
//   2 Basic: M_in=5, mpl_in=3, start pulse -> busy high 4 cycles, then done 1 cycle;
//     product=11'd15.
//   3 Corners: 127*15 -> 1905; 0*15 -> 0; 127*0 -> 0; 1*1 -> 1;
//     each with done exactly NW+1 edges after the request cycle.
//   4 Start while busy: start=1 held with M_in=9, mpl_in=9 during RUN of 6*7
//     -> product=42; the second request is taken only in DONE, giving 81 five cycles later.
//   5 Reset mid-op: start 100*13, Rst=1 at iter==2 -> no done pulse, product=0,
//     state IDLE; a fresh 3*4 request then returns 12.
//   6 Back-to-back: start=1 held continuously with 10*10 then 2*9 -> done pulses
//     5 cycles apart, products 100 then 18; busy low only during the DONE cycles.

Source files
------------

// File: rtl/lhn_seq_mult_ctrl.sv
// Sequential shift-add multiplier controller: one operand pair per start, NW add/shift
// steps, unsigned product presented with a busy/done handshake.
module lhn_seq_mult_ctrl #(
  parameter int MW = 7,
  parameter int NW = 4,
  parameter int CW = 2
) (
  input  logic               clock,
  input  logic               Rst,
  input  logic               start,
  input  logic [MW-1:0]      M_in,
  input  logic [NW-1:0]      mpl_in,
  output logic               busy,
  output logic               done,
  output logic [MW+NW-1:0]   product,
  output logic [CW-1:0]      iter
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [MW-1:0]      m_q, m_d;
  logic [MW-1:0]      ph_q, ph_d;
  logic [NW-1:0]      mpl_q, mpl_d;
  logic [CW-1:0]      iter_q, iter_d;
  logic [MW+NW-1:0]   prod_q, prod_d;
  logic               busy_q, done_q;
  logic [MW-1:0]      pp;
  logic [MW:0]        sum;

  // The carry out of ph + pp is kept and shifted into ph, so nothing is lost
  // before the shift; the bit falling off the low end of ph enters mpl.
  always_comb begin
    pp      = mpl_q[0] ? m_q : '0;
    sum     = {1'b0, ph_q} + {1'b0, pp};
    state_d = state_q;
    m_d     = m_q;
    ph_d    = ph_q;
    mpl_d   = mpl_q;
    iter_d  = iter_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          m_d     = M_in;
          ph_d    = '0;
          mpl_d   = mpl_in;
          iter_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        ph_d   = sum[MW:1];
        mpl_d  = {sum[0], mpl_q[NW-1:1]};
        iter_d = iter_q + CW'(1);
        if (iter_q == CW'(NW - 1)) begin
          prod_d  = {sum[MW:1], sum[0], mpl_q[NW-1:1]};
          iter_d  = '0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        iter_d  = '0;
      end
    endcase
  end

  // busy/done are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (Rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      ph_q    <= '0;
      mpl_q   <= '0;
      iter_q  <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      ph_q    <= ph_d;
      mpl_q   <= mpl_d;
      iter_q  <= iter_d;
      prod_q  <= prod_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;
  assign iter    = iter_q;

endmodule

// File: tb/tb_lhn_seq_mult_ctrl.sv
// Self-checking bench for lhn_seq_mult_ctrl: expected products are queued when a
// request is driven and popped when the done pulse appears.
module tb_lhn_seq_mult_ctrl;

  logic        clock;
  logic        Rst;
  logic        start;
  logic [6:0]  M_in;
  logic [3:0]  mpl_in;
  logic        busy;
  logic        done;
  logic [10:0] product;
  logic [1:0]  iter;

  int          total;
  int          bad;
  logic [10:0] expQ[$];

  lhn_seq_mult_ctrl #(.MW(7), .NW(4), .CW(2)) dut (
    .clock   (clock),
    .Rst     (Rst),
    .start   (start),
    .M_in    (M_in),
    .mpl_in  (mpl_in),
    .busy    (busy),
    .done    (done),
    .product (product),
    .iter    (iter)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [6:0] m, input logic [3:0] p);
    logic [10:0] e;
    start  = 1'b1;
    M_in   = m;
    mpl_in = p;
    e      = 11'(m) * 11'(p);
    expQ.push_back(e);
  endtask

  // Ticks until done, checking latency, busy during the wait, and the popped product.
  task automatic wait_done(input string name, input int expEdges, input bit dropStart);
    int          n;
    bit          seen;
    bit          busyErr;
    logic [10:0] e;
    n       = 0;
    seen    = 1'b0;
    busyErr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (dropStart && n == 1) start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busyErr = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s_timeout: no done within %0d edges", name, n);
      return;
    end
    if (n != expEdges) begin
      bad++;
      $display("[TB] FAIL %s_latency: got %0d edges, expected %0d", name, n, expEdges);
    end
    total++;
    if (busyErr || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_busy: busy wrong during run or done cycle (now %b, expected 0)", name, busy);
    end
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s_sb: done with empty scoreboard, product %0d", name, product);
    end else begin
      e = expQ.pop_front();
      if (product !== e) begin
        bad++;
        $display("[TB] FAIL %s_product: got %0d expected %0d", name, product, e);
      end
    end
  endtask

  task automatic test_reset();
    Rst    = 1'b1;
    start  = 1'b1;
    M_in   = 7'd5;
    mpl_in = 4'd3;
    tick();
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
    total++;
    if (product !== 11'd0) begin bad++; $display("[TB] FAIL rst_product: got %0d expected 0", product); end
    total++;
    if (iter !== 2'd0) begin bad++; $display("[TB] FAIL rst_iter: got %0d expected 0", iter); end
    Rst   = 1'b0;
    start = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [10:0] e;
    req(7'd5, 4'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL basic_run%0d: busy=%b done=%b expected busy=1 done=0", i, busy, done);
      end
      total++;
      if (product !== 11'd0) begin
        bad++;
        $display("[TB] FAIL basic_hold%0d: product %0d visible during run, expected 0", i, product);
      end
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_done: done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    e = expQ.pop_front();
    total++;
    if (product !== e) begin bad++; $display("[TB] FAIL basic_product: got %0d expected %0d", product, e); end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse: done=%b expected 0", done); end
  endtask

  task automatic test_corners();
    logic [6:0] ms[4];
    logic [3:0] ps[4];
    ms = '{7'd127, 7'd0, 7'd127, 7'd1};
    ps = '{4'd15, 4'd15, 4'd0, 4'd1};
    for (int i = 0; i < 4; i++) begin
      req(ms[i], ps[i]);
      wait_done($sformatf("corner%0d", i), 5, 1'b1);
      tick();
      total++;
      if (done !== 1'b0) begin bad++; $display("[TB] FAIL corner%0d_pulse: done=%b expected 0", i, done); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [10:0] e;
    req(7'd6, 4'd7);
    tick();
    M_in   = 7'd9;
    mpl_in = 4'd9;
    e      = 11'd81;
    expQ.push_back(e);
    wait_done("busy42", 4, 1'b0);
    wait_done("busy81", 5, 1'b1);
    tick();
  endtask

  task automatic test_reset_midop();
    int pulses;
    start  = 1'b1;
    M_in   = 7'd100;
    mpl_in = 4'd13;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (iter !== 2'd2) begin bad++; $display("[TB] FAIL mid_iter: got %0d expected 2", iter); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    total++;
    if (product !== 11'd0) begin bad++; $display("[TB] FAIL mid_product: got %0d expected 0", product); end
    total++;
    if (iter !== 2'd0) begin bad++; $display("[TB] FAIL mid_iter0: got %0d expected 0", iter); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL mid_abort: got %0d active cycles expected 0", pulses); end
    req(7'd3, 4'd4);
    wait_done("mid12", 5, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    req(7'd10, 4'd10);
    tick();
    M_in   = 7'd2;
    mpl_in = 4'd9;
    e      = 11'd18;
    expQ.push_back(e);
    wait_done("b2b100", 4, 1'b0);
    wait_done("b2b18", 5, 1'b0);
    start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL sb_left: got %0d entries expected 0", expQ.size()); end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    Rst    = 1'b1;
    start  = 1'b0;
    M_in   = '0;
    mpl_in = '0;
    test_reset();
    test_basic();
    test_corners();
    test_start_while_busy();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
